// File: rtl/kpad_pkg.sv
// Shared constants, settle-state encoding and key classification for the keypad entry block.
// Build option: define KPAD_HEX_EN for hexadecimal entry (keys A-D become digits 10-13).
package kpad_pkg;

  localparam logic [3:0] KEY_ENTER      = 4'hE;
  localparam logic [3:0] KEY_BKSP       = 4'hF;
  localparam int         HEX_MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_WAIT_REL = 2'd2
  } settle_state_e;

  // A-D count as digits only in hex mode; E and F are always command keys.
  function automatic logic is_digit(input logic [3:0] code);
`ifdef KPAD_HEX_EN
    return code <= 4'd13;
`else
    return code <= 4'd9;
`endif
  endfunction

endpackage

// File: rtl/kpad_settle.sv
// Key debounce: a key must stay down SETTLE_CYC cycles before one key_evt fires,
// then the FSM waits for release so a held key never repeats.
module kpad_settle
  import kpad_pkg::*;
#(
  parameter int SETTLE_CYC = 1_100_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    key_code,
  input  logic          key_down,
  output logic          key_evt,
  output logic [3:0]    key_val,
  output settle_state_e state
);

  localparam int              CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      key_evt <= 1'b0;
      key_val <= 4'd0;
    end else begin
      key_evt <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (key_down) state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (!key_down) begin
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            key_evt <= 1'b1;
            key_val <= key_code;
            state   <= ST_WAIT_REL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_REL: begin
          if (!key_down) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad number entry: debounced keys build a number that Enter hands to the CPU.
// Build option: define KPAD_HEX_EN for hex entry (shift-by-4 datapath, 8-digit cap).
module keypad_entry
  import kpad_pkg::*;
#(
  parameter int SETTLE_CYC     = 1_100_000,
  parameter int DEC_MAX_DIGITS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_code,
  input  logic        key_down,
  input  logic        clr,
  input  logic        rd_ack,
  output logic [31:0] entry_val,
  output logic [3:0]  digit_cnt,
  output logic [31:0] out_val,
  output logic        out_valid,
  output logic        drop,
  output logic [1:0]  settle_state
);

`ifdef KPAD_HEX_EN
  localparam int MAX_DIGITS = HEX_MAX_DIGITS;
`else
  localparam int MAX_DIGITS = DEC_MAX_DIGITS;
`endif
  localparam logic [3:0] DIGIT_CAP = 4'(MAX_DIGITS);

  logic          key_evt;
  logic [3:0]    key_val;
  settle_state_e st;
  logic [31:0]   entry_push;
  logic [31:0]   entry_pop;
  logic          enter_hit;
  logic          enter_accept;
  logic          enter_blocked;
  logic          ack_live;

  kpad_settle #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .key_code (key_code),
    .key_down (key_down),
    .key_evt  (key_evt),
    .key_val  (key_val),
    .state    (st)
  );

  assign settle_state = st;

`ifdef KPAD_HEX_EN
  assign entry_push = {entry_val[27:0], key_val};
  assign entry_pop  = {4'd0, entry_val[31:4]};
`else
  assign entry_push = entry_val * 32'd10 + {28'd0, key_val};
  assign entry_pop  = entry_val / 32'd10;
`endif

  // clr swallows a coincident key event; an empty entry never commits.
  assign enter_hit     = key_evt && !clr && (key_val == KEY_ENTER) && (digit_cnt != 4'd0);
  assign enter_accept  = enter_hit && (!out_valid || rd_ack);
  assign enter_blocked = enter_hit && out_valid && !rd_ack;
  assign ack_live      = rd_ack && out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_val <= 32'd0;
      digit_cnt <= 4'd0;
      out_val   <= 32'd0;
      out_valid <= 1'b0;
      drop      <= 1'b0;
    end else begin
      if (clr) begin
        entry_val <= 32'd0;
        digit_cnt <= 4'd0;
      end else if (key_evt) begin
        if (is_digit(key_val)) begin
          if (digit_cnt < DIGIT_CAP) begin
            entry_val <= entry_push;
            digit_cnt <= digit_cnt + 4'd1;
          end
        end else if (key_val == KEY_BKSP) begin
          if (digit_cnt != 4'd0) begin
            entry_val <= entry_pop;
            digit_cnt <= digit_cnt - 4'd1;
          end
        end else if (enter_accept) begin
          entry_val <= 32'd0;
          digit_cnt <= 4'd0;
        end
      end

      if (enter_accept) begin
        out_val   <= entry_val;
        out_valid <= 1'b1;
      end else if (ack_live) begin
        out_valid <= 1'b0;
      end

      if (ack_live) drop <= 1'b0;
      else if (enter_blocked) drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry with SETTLE_CYC=4: directed table, corner sequences, random vs model.
module tb_keypad_entry;
  import kpad_pkg::*;

`ifdef KPAD_HEX_EN
  localparam int BASE = 16;
  localparam int CAP  = 8;
`else
  localparam int BASE = 10;
  localparam int CAP  = 9;
`endif

  localparam int OP_PRESS     = 0;
  localparam int OP_ACK       = 1;
  localparam int OP_CLR       = 2;
  localparam int OP_PRESS_ACK = 3;

  typedef struct {
    int          op;
    logic [3:0]  code;
    logic [31:0] e;
    logic [3:0]  c;
    logic [31:0] o;
    logic        v;
    logic        d;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_code = 4'd0;
  logic        key_down = 1'b0;
  logic        clr = 1'b0;
  logic        rd_ack = 1'b0;
  logic [31:0] entry_val;
  logic [3:0]  digit_cnt;
  logic [31:0] out_val;
  logic        out_valid;
  logic        drop;
  logic [1:0]  settle_state;

  int n_vec = 0;
  int n_err = 0;
  int evt_cnt = 0;

  vec_t tbl[$];

  // behavioural model: entered digits as a list, committed value, flags
  int          m_q[$];
  logic [31:0] m_out;
  logic        m_v;
  logic        m_d;

  keypad_entry #(.SETTLE_CYC(4), .DEC_MAX_DIGITS(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_code     (key_code),
    .key_down     (key_down),
    .clr          (clr),
    .rd_ack       (rd_ack),
    .entry_val    (entry_val),
    .digit_cnt    (digit_cnt),
    .out_val      (out_val),
    .out_valid    (out_valid),
    .drop         (drop),
    .settle_state (settle_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.key_evt === 1'b1) evt_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e, input logic [3:0] c,
                         input logic [31:0] o, input logic v, input logic d);
    chk({tag, ".entry_val"}, entry_val, e);
    chk({tag, ".digit_cnt"}, {28'd0, digit_cnt}, {28'd0, c});
    chk({tag, ".out_val"}, out_val, o);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".drop"}, {31'd0, drop}, {31'd0, d});
  endtask

  // one full press; ack/c are pulsed on the cycle the key event reaches the datapath
  task automatic press_pulse(input logic [3:0] code, input logic ack, input logic c);
    @(negedge clk);
    key_code = code;
    key_down = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rd_ack = ack;
    clr    = c;
    @(negedge clk);
    rd_ack   = 1'b0;
    clr      = 1'b0;
    key_down = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_q.delete();
    m_out = 32'd0;
    m_v   = 1'b0;
    m_d   = 1'b0;
  endtask

  function automatic logic [31:0] model_val();
    logic [31:0] v = 32'd0;
    foreach (m_q[i]) v = v * BASE + 32'(m_q[i]);
    return v;
  endfunction

  function automatic bit model_is_digit(input int code);
`ifdef KPAD_HEX_EN
    return code <= 13;
`else
    return code <= 9;
`endif
  endfunction

  function automatic void model_press(input int code, input bit ack, input bit c);
    bit accepted = 0;
    if (c) begin
      m_q.delete();
    end else if (model_is_digit(code)) begin
      if (m_q.size() < CAP) m_q.push_back(code);
    end else if (code == 15) begin
      if (m_q.size() > 0) void'(m_q.pop_back());
    end else if (code == 14 && m_q.size() > 0) begin
      if (!m_v || ack) begin
        m_out = model_val();
        m_q.delete();
        accepted = 1;
      end else begin
        m_d = 1'b1;
      end
    end
    if (accepted) begin
      m_v = 1'b1;
      if (ack) m_d = 1'b0;
    end else if (ack && m_v) begin
      m_v = 1'b0;
      m_d = 1'b0;
    end
  endfunction

  function automatic void add(input int op, input logic [3:0] code, input logic [31:0] e,
                              input logic [3:0] c, input logic [31:0] o, input logic v,
                              input logic d);
    vec_t t;
    t.op = op; t.code = code; t.e = e; t.c = c; t.o = o; t.v = v; t.d = d;
    tbl.push_back(t);
  endfunction

  initial begin
    logic [31:0] ev;
    logic [31:0] cap_val;
    int          e0;

    // ---------------- directed table ----------------
    add(OP_PRESS, 4'd1, 32'd1, 4'd1, 32'd0, 1'b0, 1'b0);
    add(OP_PRESS, 4'd2, 32'(BASE + 2), 4'd2, 32'd0, 1'b0, 1'b0);
    add(OP_PRESS, 4'd3, 32'(BASE * BASE + 2 * BASE + 3), 4'd3, 32'd0, 1'b0, 1'b0);
    add(OP_PRESS, KEY_ENTER, 32'd0, 4'd0, 32'(BASE * BASE + 2 * BASE + 3), 1'b1, 1'b0);
    add(OP_ACK, 4'd0, 32'd0, 4'd0, 32'(BASE * BASE + 2 * BASE + 3), 1'b0, 1'b0);
    add(OP_PRESS, 4'd4, 32'd4, 4'd1, 32'(BASE * BASE + 2 * BASE + 3), 1'b0, 1'b0);
    add(OP_PRESS, 4'd7, 32'(4 * BASE + 7), 4'd2, 32'(BASE * BASE + 2 * BASE + 3), 1'b0, 1'b0);
    add(OP_PRESS, KEY_BKSP, 32'd4, 4'd1, 32'(BASE * BASE + 2 * BASE + 3), 1'b0, 1'b0);
    add(OP_PRESS, KEY_BKSP, 32'd0, 4'd0, 32'(BASE * BASE + 2 * BASE + 3), 1'b0, 1'b0);
    add(OP_PRESS, KEY_BKSP, 32'd0, 4'd0, 32'(BASE * BASE + 2 * BASE + 3), 1'b0, 1'b0);
    add(OP_PRESS, KEY_ENTER, 32'd0, 4'd0, 32'(BASE * BASE + 2 * BASE + 3), 1'b0, 1'b0);
    add(OP_PRESS, 4'd9, 32'd9, 4'd1, 32'(BASE * BASE + 2 * BASE + 3), 1'b0, 1'b0);
    add(OP_PRESS, KEY_ENTER, 32'd0, 4'd0, 32'd9, 1'b1, 1'b0);
    add(OP_PRESS, 4'd8, 32'd8, 4'd1, 32'd9, 1'b1, 1'b0);
    add(OP_PRESS, KEY_ENTER, 32'd8, 4'd1, 32'd9, 1'b1, 1'b1);
    add(OP_PRESS_ACK, KEY_ENTER, 32'd0, 4'd0, 32'd8, 1'b1, 1'b0);
    add(OP_ACK, 4'd0, 32'd0, 4'd0, 32'd8, 1'b0, 1'b0);
    add(OP_ACK, 4'd0, 32'd0, 4'd0, 32'd8, 1'b0, 1'b0);
`ifdef KPAD_HEX_EN
    add(OP_PRESS, 4'hA, 32'hA, 4'd1, 32'd8, 1'b0, 1'b0);
    add(OP_PRESS, 4'hB, 32'hAB, 4'd2, 32'd8, 1'b0, 1'b0);
`else
    add(OP_PRESS, 4'hA, 32'd0, 4'd0, 32'd8, 1'b0, 1'b0);
    add(OP_PRESS, 4'hB, 32'd0, 4'd0, 32'd8, 1'b0, 1'b0);
`endif
    add(OP_CLR, 4'd0, 32'd0, 4'd0, 32'd8, 1'b0, 1'b0);
    ev = 32'd0;
    for (int i = 0; i < 10; i++) begin
      if (i < CAP) ev = ev * BASE + 32'd9;
      add(OP_PRESS, 4'd9, ev, 4'((i + 1 < CAP) ? i + 1 : CAP), 32'd8, 1'b0, 1'b0);
    end
    cap_val = ev;
    add(OP_PRESS, KEY_ENTER, 32'd0, 4'd0, cap_val, 1'b1, 1'b0);

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk_all("reset", 32'd0, 4'd0, 32'd0, 1'b0, 1'b0);
    chk("reset.settle_state", {30'd0, settle_state}, {30'd0, ST_IDLE});
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_PRESS:     press_pulse(tbl[i].code, 1'b0, 1'b0);
        OP_PRESS_ACK: press_pulse(tbl[i].code, 1'b1, 1'b0);
        OP_ACK:       pulse_ack();
        default:      pulse_clr();
      endcase
      chk_all($sformatf("tbl[%0d]", i), tbl[i].e, tbl[i].c, tbl[i].o, tbl[i].v, tbl[i].d);
    end

    // ---------------- bounce: short burst must not register ----------------
    pulse_clr();
    e0 = evt_cnt;
    @(negedge clk);
    key_code = 4'd5;
    key_down = 1'b1;
    repeat (2) @(negedge clk);
    key_down = 1'b0;
    @(negedge clk);
    key_down = 1'b1;
    repeat (6) @(negedge clk);
    key_down = 1'b0;
    repeat (2) @(negedge clk);
    chk("bounce.evt_count", 32'(evt_cnt - e0), 32'd1);
    chk_all("bounce", 32'd5, 4'd1, cap_val, 1'b1, 1'b0);

    // ---------------- clr coincident with a key event ----------------
    e0 = evt_cnt;
    press_pulse(4'd7, 1'b0, 1'b1);
    chk("clr_evt.evt_count", 32'(evt_cnt - e0), 32'd1);
    chk_all("clr_evt", 32'd0, 4'd0, cap_val, 1'b1, 1'b0);

    // ---------------- reset during SETTLE, key held through release ----------------
    @(negedge clk);
    key_code = 4'd3;
    key_down = 1'b1;
    repeat (2) @(negedge clk);
    e0  = evt_cnt;
    rst = 1'b1;
    #1;
    chk_all("rst_mid", 32'd0, 4'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_mid.no_evt", 32'(evt_cnt - e0), 32'd0);
    repeat (4) @(negedge clk);
    chk("rst_rel.early_entry", entry_val, 32'd0);
    chk("rst_rel.early_evt", 32'(evt_cnt - e0), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_rel.evt", 32'(evt_cnt - e0), 32'd1);
    chk_all("rst_rel", 32'd3, 4'd1, 32'd0, 1'b0, 1'b0);
    key_down = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- random against the model ----------------
    do_reset();
    for (int n = 0; n < 80; n++) begin
      int r;
      int code;
      r    = $urandom_range(0, 9);
      code = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      if (r <= 6) begin
        press_pulse(4'(code), 1'b0, 1'b0);
        model_press(code, 1'b0, 1'b0);
      end else if (r == 7) begin
        pulse_ack();
        if (m_v) begin
          m_v = 1'b0;
          m_d = 1'b0;
        end
      end else if (r == 8) begin
        pulse_clr();
        m_q.delete();
      end else begin
        press_pulse(KEY_ENTER, 1'b1, 1'b0);
        model_press(14, 1'b1, 1'b0);
      end
      chk_all($sformatf("rnd[%0d]", n), model_val(), 4'(m_q.size()), m_out, m_v, m_d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
